// File: rtl/sorted_ascii_formatter.sv
// Converts each sorted 8-bit value to unsigned decimal ASCII, one byte per
// handshake, followed by SEP, or by CR LF after every DEPTH values.
module sorted_ascii_formatter #(
   parameter int         DEPTH   = 10,
   parameter int         COUNT_W = 4,
   parameter logic [7:0] SEP     = 8'h20
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HUND,
      ST_TENS,
      ST_ONES,
      ST_SEP,
      ST_CR,
      ST_LF
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         tens_q, tens_d;
   logic [3:0]         ones_q, ones_d;
   logic [COUNT_W-1:0] line_cnt_q, line_cnt_d;
   logic [7:0]         data_q, data_d;
   logic               valid_q, valid_d;

   logic [1:0] hund_c;
   logic [7:0] rem_c;
   logic [3:0] tens_c;
   logic [3:0] ones_c;
   logic       out_hs;

   // Digit split of the incoming value, only consumed in IDLE on accept.
   always_comb begin
      if (data_i >= 8'd200) begin
         hund_c = 2'd2;
         rem_c  = data_i - 8'd200;
      end else if (data_i >= 8'd100) begin
         hund_c = 2'd1;
         rem_c  = data_i - 8'd100;
      end else begin
         hund_c = 2'd0;
         rem_c  = data_i;
      end
      tens_c = '0;
      for (int unsigned i = 1; i < 10; i++) begin
         if (rem_c >= 8'(10 * i)) tens_c = 4'(i);
      end
      ones_c = 4'(rem_c - 8'(10 * tens_c));
   end

   assign out_hs = valid_q && ready_i;

   always_comb begin
      state_d    = state_q;
      tens_d     = tens_q;
      ones_d     = ones_q;
      line_cnt_d = line_cnt_q;
      data_d     = data_q;
      valid_d    = valid_q;
      unique case (state_q)
         ST_IDLE: begin
            if (valid_i) begin
               tens_d  = tens_c;
               ones_d  = ones_c;
               valid_d = 1'b1;
               // Leading-zero suppression: start at the first printed digit.
               if (hund_c != 2'd0) begin
                  state_d = ST_HUND;
                  data_d  = 8'h30 + {6'd0, hund_c};
               end else if (tens_c != 4'd0) begin
                  state_d = ST_TENS;
                  data_d  = 8'h30 + {4'd0, tens_c};
               end else begin
                  state_d = ST_ONES;
                  data_d  = 8'h30 + {4'd0, ones_c};
               end
            end
         end
         ST_HUND: begin
            if (out_hs) begin
               state_d = ST_TENS;
               data_d  = 8'h30 + {4'd0, tens_q};
            end
         end
         ST_TENS: begin
            if (out_hs) begin
               state_d = ST_ONES;
               data_d  = 8'h30 + {4'd0, ones_q};
            end
         end
         ST_ONES: begin
            if (out_hs) begin
               if (line_cnt_q == COUNT_W'(DEPTH - 1)) begin
                  state_d = ST_CR;
                  data_d  = 8'h0D;
               end else begin
                  state_d = ST_SEP;
                  data_d  = SEP;
               end
            end
         end
         ST_SEP: begin
            if (out_hs) begin
               state_d    = ST_IDLE;
               valid_d    = 1'b0;
               line_cnt_d = line_cnt_q + 1'b1;
            end
         end
         ST_CR: begin
            if (out_hs) begin
               state_d = ST_LF;
               data_d  = 8'h0A;
            end
         end
         ST_LF: begin
            if (out_hs) begin
               state_d    = ST_IDLE;
               valid_d    = 1'b0;
               line_cnt_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         tens_q     <= '0;
         ones_q     <= '0;
         line_cnt_q <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         tens_q     <= tens_d;
         ones_q     <= ones_d;
         line_cnt_q <= line_cnt_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
      end
   end

   assign ready_o = (state_q == ST_IDLE);
   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: tb/tb_sorted_ascii_formatter.sv
// Self-checking bench for sorted_ascii_formatter: fixed vectors, timing and
// backpressure sequences, reset mid-emission, and a randomized stream model.
module tb_sorted_ascii_formatter;

   typedef logic [7:0] bq_t [$];
   typedef struct {
      logic [7:0] v;
      string      exp;
      int         cyc;
   } vec_t;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b1;
   logic [7:0] data_i = '0;
   logic       valid_i = 1'b0;
   logic       ready_o;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ready_i = 1'b0;

   int checks = 0;
   int errors = 0;
   bq_t rx;

   sorted_ascii_formatter #(.DEPTH(10), .COUNT_W(4), .SEP(8'h20)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .data_i  (data_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_o  (data_o),
      .valid_o (valid_o),
      .ready_i (ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   function automatic bq_t str2q(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   task automatic check_stream(input string name, input bq_t exp);
      int bad = -1;
      int n = (rx.size() < exp.size()) ? rx.size() : exp.size();
      logic [7:0] g, e;
      checks++;
      for (int i = 0; i < n; i++) if (bad < 0 && rx[i] !== exp[i]) bad = i;
      if (bad < 0 && rx.size() != exp.size()) bad = n;
      if (bad >= 0) begin
         errors++;
         g = (bad < rx.size()) ? rx[bad] : 8'h00;
         e = (bad < exp.size()) ? exp[bad] : 8'h00;
         $display("FAIL %s: got %0d bytes, required %0d, first difference at byte %0d (got %h, required %h)",
                  name, rx.size(), exp.size(), bad, g, e);
      end
   endtask

   // One clock: records the output handshake, then checks output stability
   // across any cycle where valid_o was held off by ready_i.
   task automatic tick();
      logic pv, pr, prst;
      logic [7:0] pd;
      pv = valid_o; pr = ready_i; pd = data_o; prst = reset_i;
      if (!prst && pv && pr) rx.push_back(pd);
      @(posedge clk_i);
      #1;
      if (!prst && pv && !pr) begin
         check("hold_valid", valid_o, 1);
         check("hold_data", data_o, pd);
      end
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      valid_i = 1'b0;
      tick();
      tick();
      reset_i = 1'b0;
      rx.delete();
   endtask

   task automatic send_value(input logic [7:0] v, output int cycles);
      int n = 0;
      while (!ready_o && n < 200) begin tick(); n++; end
      check("ready_timeout_pre", n < 200, 1);
      data_i  = v;
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      cycles = 1;
      while (!ready_o && cycles < 200) begin tick(); cycles++; end
      check("ready_timeout_post", cycles < 200, 1);
   endtask

   initial begin
      vec_t vecs[9];
      int cyc, idx, budget;
      string s;
      bq_t model;
      logic acc;
      logic [7:0] batch[11];

      vecs[0] = '{8'd0,   "0 ",   3};
      vecs[1] = '{8'd7,   "7 ",   3};
      vecs[2] = '{8'd42,  "42 ",  4};
      vecs[3] = '{8'd100, "100 ", 5};
      vecs[4] = '{8'd105, "105 ", 5};
      vecs[5] = '{8'd255, "255 ", 5};
      vecs[6] = '{8'd9,   "9 ",   3};
      vecs[7] = '{8'd200, "200 ", 5};
      vecs[8] = '{8'd10,  "10 ",  4};
      batch = '{8'd3, 8'd5, 8'd9, 8'd12, 8'd40, 8'd77, 8'd100, 8'd150, 8'd201, 8'd250, 8'd8};

      // Reset state, and ready_i with no valid_o must do nothing
      ready_i = 1'b1;
      do_reset();
      check("reset_ready", ready_o, 1);
      check("reset_valid", valid_o, 0);
      check("reset_data", data_o, 8'h00);
      tick(); tick();
      check("idle_valid", valid_o, 0);
      check("idle_no_bytes", rx.size(), 0);

      // Value 0: one-cycle latency, consecutive characters, return to ready
      data_i = 8'd0; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      check("zero_c0_valid", valid_o, 1);
      check("zero_c0_data", data_o, 8'h30);
      check("zero_c0_ready", ready_o, 0);
      tick();
      check("zero_c1_valid", valid_o, 1);
      check("zero_c1_data", data_o, 8'h20);
      tick();
      check("zero_end_valid", valid_o, 0);
      check("zero_end_ready", ready_o, 1);
      check_stream("zero_stream", str2q("0 "));

      // Table of single values
      do_reset();
      for (int i = 0; i < 9; i++) begin
         rx.delete();
         send_value(vecs[i].v, cyc);
         check_stream($sformatf("vec_%0d_stream", vecs[i].v), str2q(vecs[i].exp));
         check($sformatf("vec_%0d_cycles", vecs[i].v), cyc, vecs[i].cyc);
      end

      // Full sorted batch closes the line with CR LF; an 11th value starts anew
      do_reset();
      for (int i = 0; i < 10; i++) begin
         send_value(batch[i], cyc);
         if (i == 9) check("line_end_cycles", cyc, 6);
      end
      check_stream("batch_stream", str2q("3 5 9 12 40 77 100 150 201 250\r\n"));
      rx.delete();
      send_value(batch[10], cyc);
      check_stream("new_line_stream", str2q("8 "));

      // Backpressure: 5 stalled cycles at each character of 123
      do_reset();
      ready_i = 1'b0;
      data_i = 8'd123; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      s = "123 ";
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_data_%0d", c), data_o, s[c]);
            check($sformatf("bp_valid_%0d", c), valid_o, 1);
            check($sformatf("bp_ready_%0d", c), ready_o, 0);
            tick();
         end
         ready_i = 1'b1;
         tick();
         ready_i = 1'b0;
      end
      check("bp_end_ready", ready_o, 1);
      check("bp_end_valid", valid_o, 0);
      check_stream("bp_stream", str2q("123 "));

      // Reset mid-emission drops the rest of 123 and clears the line count
      ready_i = 1'b1;
      do_reset();
      for (int i = 1; i <= 5; i++) send_value(8'(i), cyc);
      rx.delete();
      data_i = 8'd123; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      tick();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      check("midrst_valid", valid_o, 0);
      check("midrst_ready", ready_o, 1);
      check("midrst_data", data_o, 8'h00);
      check_stream("midrst_partial", str2q("1"));
      rx.delete();
      s = "";
      for (int i = 0; i < 10; i++) begin
         send_value(8'd9, cyc);
         s = (i == 9) ? {s, "9\r\n"} : {s, "9 "};
      end
      check_stream("midrst_after", str2q(s));

      // Randomized stream vs. decimal-string model
      do_reset();
      model.delete();
      idx = 0;
      budget = 0;
      data_i = 8'($urandom_range(0, 255));
      valid_i = 1'b1;
      while (idx < 1000 && budget < 40000) begin
         ready_i = ($urandom_range(0, 3) != 0);
         acc = valid_i && ready_o;
         if (acc) begin
            s = $sformatf("%0d", data_i);
            s = (idx % 10 == 9) ? {s, "\r\n"} : {s, " "};
            for (int j = 0; j < s.len(); j++) model.push_back(s[j]);
         end
         tick();
         budget++;
         if (acc) begin
            idx++;
            data_i = 8'($urandom_range(0, 255));
         end
      end
      valid_i = 1'b0;
      check("rand_accept_timeout", idx, 1000);
      ready_i = 1'b1;
      budget = 0;
      while ((valid_o || !ready_o) && budget < 100) begin tick(); budget++; end
      check("rand_drain_timeout", budget < 100, 1);
      check_stream("rand_stream", model);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
